// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default sizing for the memory-port arbiter slice.
// The ARB_ROUND_ROBIN_EN macro (see arb_pick) selects round-robin contention.
package mem_arb_pkg;

  typedef enum logic {
    IDLE,
    EXT_LOCK
  } arb_state_e;

  typedef enum logic {
    OWN_CPU,
    OWN_EXT
  } owner_e;

  localparam int unsigned DEF_WIDTH    = 16;
  localparam int unsigned DEF_MAX_HOLD = 8;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU, EXT and data-memory signal bundle for mem_port_arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if #(
  parameter int unsigned WIDTH = 16
);
  logic             cpu_req;
  logic             cpu_we;
  logic [WIDTH-1:0] cpu_adr;
  logic [WIDTH-1:0] cpu_wdata;
  logic             cpu_gnt;
  logic             cpu_rvalid;
  logic [WIDTH-1:0] cpu_rdata;

  logic             ext_req;
  logic             ext_we;
  logic [WIDTH-1:0] ext_adr;
  logic [WIDTH-1:0] ext_wdata;
  logic             ext_lock;
  logic             ext_gnt;
  logic             ext_rvalid;
  logic [WIDTH-1:0] ext_rdata;

  logic [WIDTH-1:0] mem_adr;
  logic [WIDTH-1:0] mem_wd;
  logic             mem_read;
  logic             mem_write;
  logic [WIDTH-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_adr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  ext_req, ext_we, ext_adr, ext_wdata, ext_lock,
    output ext_gnt, ext_rvalid, ext_rdata,
    output mem_adr, mem_wd, mem_read, mem_write,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_adr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output ext_req, ext_we, ext_adr, ext_wdata, ext_lock,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  mem_adr, mem_wd, mem_read, mem_write,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Two-input picker: sole requester wins; on contention the CPU wins, or with
// ARB_ROUND_ROBIN_EN defined, whichever requester is not last_winner.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic   cpu_req_i,
  input  logic   ext_req_i,
  input  owner_e last_winner_i,
  output logic   cpu_pick_o,
  output logic   ext_pick_o
);

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic cpu_wins;

  always_comb begin
    cpu_wins   = !RR_EN || (last_winner_i == OWN_EXT);
    cpu_pick_o = cpu_req_i && (!ext_req_i || cpu_wins);
    ext_pick_o = ext_req_i && (!cpu_req_i || !cpu_wins);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a CPU and an EXT (loader/debug) requester onto one single-port
// data memory, with EXT burst locking bounded by MAX_HOLD while the CPU waits.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);

  arb_state_e       state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  owner_e           last_winner_q;
  logic             pick_cpu, pick_ext;
  logic             cpu_gnt, ext_gnt, hold_full;
  logic             cpu_rvalid_q, ext_rvalid_q;
  logic [WIDTH-1:0] cpu_rdata_q, ext_rdata_q;

  arb_pick u_pick (
    .cpu_req_i     (bus.cpu_req),
    .ext_req_i     (bus.ext_req),
    .last_winner_i (last_winner_q),
    .cpu_pick_o    (pick_cpu),
    .ext_pick_o    (pick_ext)
  );

  assign hold_full = (hold_q == HW'(MAX_HOLD));

  always_comb begin
    cpu_gnt = 1'b0;
    ext_gnt = 1'b0;
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        cpu_gnt = pick_cpu;
        ext_gnt = pick_ext;
        if (pick_ext && bus.ext_lock) begin
          state_d = EXT_LOCK;
          hold_d  = HW'(1);
        end else begin
          hold_d  = '0;
        end
      end
      EXT_LOCK: begin
        if (hold_full && bus.cpu_req) begin
          cpu_gnt = 1'b1;
          state_d = IDLE;
          hold_d  = '0;
        end else if (bus.ext_req && bus.ext_lock) begin
          ext_gnt = 1'b1;
          hold_d  = hold_full ? hold_q : hold_q + HW'(1);
        end else begin
          // Lock dropped: EXT gets nothing this cycle, so a CPU request is sole.
          cpu_gnt = bus.cpu_req;
          state_d = IDLE;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
    if (rst) begin
      cpu_gnt = 1'b0;
      ext_gnt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      hold_q        <= '0;
      last_winner_q <= OWN_EXT;
      cpu_rvalid_q  <= 1'b0;
      ext_rvalid_q  <= 1'b0;
      cpu_rdata_q   <= '0;
      ext_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      cpu_rvalid_q <= cpu_gnt && !bus.cpu_we;
      ext_rvalid_q <= ext_gnt && !bus.ext_we;
      if (cpu_gnt) last_winner_q <= OWN_CPU;
      else if (ext_gnt) last_winner_q <= OWN_EXT;
      if (cpu_gnt && !bus.cpu_we) cpu_rdata_q <= bus.mem_rdata;
      if (ext_gnt && !bus.ext_we) ext_rdata_q <= bus.mem_rdata;
    end
  end

  always_comb begin
    bus.cpu_gnt    = cpu_gnt;
    bus.ext_gnt    = ext_gnt;
    bus.cpu_rvalid = cpu_rvalid_q;
    bus.ext_rvalid = ext_rvalid_q;
    bus.cpu_rdata  = cpu_rdata_q;
    bus.ext_rdata  = ext_rdata_q;
    bus.mem_adr    = '0;
    bus.mem_wd     = '0;
    if (cpu_gnt) begin
      bus.mem_adr = bus.cpu_adr;
      bus.mem_wd  = bus.cpu_wdata;
    end else if (ext_gnt) begin
      bus.mem_adr = bus.ext_adr;
      bus.mem_wd  = bus.ext_wdata;
    end
    bus.mem_read  = (cpu_gnt && !bus.cpu_we) || (ext_gnt && !bus.ext_we);
    bus.mem_write = (cpu_gnt && bus.cpu_we) || (ext_gnt && bus.ext_we);
  end

endmodule
